fetch_inst_buffer: RTL and testbench
====================================

FETCH_INST_BUFFER -- requirements
Module: fetch_inst_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, at least 8.
REQ-002 SHALL have parameter PKT_W, default `SIZE_INSTRUCTION+2*`SIZE_PC+`SIZE_CTI_LOG+1, width of one instruction packet.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port flush_i, input, 1, recovery flush from the back end.
REQ-006 SHALL have port fs2Ready_i, input, 1, FetchStage2 bundle valid this cycle.
REQ-007 SHALL have port instValid_i, input, 4, per-slot valid from FetchStage2; bit3 is slot 0.
REQ-008 SHALL have port instPacket_i, input, 4*PKT_W, slot 0 in the lowest PKT_W bits.
REQ-009 SHALL have port decodeReady_i, input, 1, decode accepts all presented slots this cycle.
REQ-010 SHALL have port bufferFull_o, output, 1, stall request to fetch.
REQ-011 SHALL have port outValid_o, output, 4, valid per output slot; bit3 is slot 0, the oldest.
REQ-012 SHALL have port outPacket_o, output, 4*PKT_W, oldest entries, same slot packing as the input.
REQ-013 SHALL have port count_o, output, log2(DEPTH)+1, current occupancy.

Function
REQ-014 SHALL be a circular FIFO with head pointer, tail pointer and count; both pointers wrap modulo DEPTH.
REQ-015 SHALL drive bufferFull_o = (DEPTH - count < 4), combinationally from registered count only.
REQ-016 SHALL enqueue when fs2Ready_i & ~bufferFull_o & ~flush_i; otherwise no write takes place.
REQ-017 SHALL write only the valid slots, compacted in order (slot 0 first) starting at tail; tail advances by popcount(instValid_i).
REQ-018 SHALL treat instValid_i as a contiguous prefix starting at bit3; a non-prefix pattern is illegal, and its result is unspecified but SHALL never corrupt count.
REQ-019 SHALL drive outValid_o[3-k] = (count > k) for k = 0..3, with outPacket_o slot k taken from entry (head+k) mod DEPTH.
REQ-020 SHALL, when decodeReady_i & ~flush_i, dequeue min(count,4) entries; head advances by the same amount.
REQ-021 SHALL, on simultaneous enqueue and dequeue, set count_next = count + nEnq - nDeq; entries written this cycle are not visible at the output this cycle (except as in REQ-029).
REQ-022 SHALL give a minimum latency of 1 cycle from enqueue to presentation at the output.
REQ-023 SHALL, on flush_i, set head, tail and count to 0 on the next edge; any same-cycle enqueue or dequeue is discarded.
REQ-024 SHALL give flush_i priority over enqueue and dequeue, and reset priority over flush_i.
REQ-025 SHALL never overflow: count never exceeds DEPTH; dequeue from an empty buffer is a no-op.

Reset
REQ-026 SHALL, on reset, clear head, tail and count to 0, so that outValid_o = 0, count_o = 0 and bufferFull_o = 0 from the next cycle.
REQ-027 SHALL not reset storage contents; data in entries not covered by count is don't-care.
REQ-028 SHALL, if reset is asserted mid-operation, discard all entries with no partial dequeue.

Configuration
REQ-029 SHALL, with FETCH_BUF_BYPASS_EN defined, present input slots directly on outValid_o/outPacket_o in the same cycle when count == 0 and an enqueue qualifies. If decodeReady_i is also high, nothing is written. Otherwise the slots are written normally.
REQ-030 SHALL, without FETCH_BUF_BYPASS_EN, have no bypass path and hold the 1-cycle minimum latency of REQ-022.

Structure
REQ-031 SHALL place PKT_W, FETCH_BANDWIDTH (4) and the count/pointer width functions in a shared package, fetch_buf_pkg.
REQ-032 SHALL implement storage as one sub-module, fetch_buf_ram: DEPTH x PKT_W, 4 write ports and 4 read ports, with index wrap handled inside.

Verification
REQ-033 Reset, then fs2Ready_i=1, instValid_i=4'b1111, decodeReady_i=0 -> count_o=4 next cycle; outValid_o=4'b1111; outPacket_o slot 0 equals input slot 0.
REQ-034 Four full bundles with decodeReady_i=0 and DEPTH=16 -> count_o=16 and bufferFull_o=1. A fifth bundle -> count stays 16 and no write occurs.
REQ-035 count=6, instValid_i=4'b1100, decodeReady_i=1 -> count_o=4 (6+2-4) next cycle; head advances 4; ordering preserved across the wrap at entry 15->0.
REQ-036 count=10 with enqueue and dequeue active and flush_i=1 -> count_o=0 and outValid_o=0 next cycle; the following bundle lands at entry 0.
REQ-037 With FETCH_BUF_BYPASS_EN, empty buffer, instValid_i=4'b1110, decodeReady_i=1 -> outValid_o=4'b1110 same cycle and count_o stays 0. Without the macro -> outValid_o=0 that cycle and 4'b1110 the next.

Source files
------------

// File: rtl/fetch_buf_pkg.sv
// Shared constants and sizing helpers for the fetch instruction buffer.
// Packet field widths fall back to defaults when the core headers do not define them.
`ifndef SIZE_INSTRUCTION
`define SIZE_INSTRUCTION 32
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 2
`endif

package fetch_buf_pkg;

   localparam int unsigned FETCH_BANDWIDTH = 4;
   localparam int unsigned PKT_W = `SIZE_INSTRUCTION + 2 * `SIZE_PC + `SIZE_CTI_LOG + 1;

   function automatic int unsigned ptr_width(int unsigned depth);
      return $clog2(depth);
   endfunction

   function automatic int unsigned cnt_width(int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   // Length of the contiguous valid prefix starting at bit3 (slot 0). Anything past the
   // first hole is ignored, so write enables and the count always agree.
   function automatic logic [2:0] prefix_len(logic [3:0] valid);
      logic [2:0] n;
      n = 3'd0;
      if (valid[3]) begin
         n = 3'd1;
         if (valid[2]) begin
            n = 3'd2;
            if (valid[1]) begin
               n = 3'd3;
               if (valid[0]) n = 3'd4;
            end
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/fetch_buf_ram.sv
// DEPTH x PKT_W storage with four write and four read ports at consecutive indices.
// Port k addresses (base + k) mod DEPTH; storage is never reset.
module fetch_buf_ram
   import fetch_buf_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PKT_W = fetch_buf_pkg::PKT_W,
   localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
   input  logic                             clk,
   input  logic [FETCH_BANDWIDTH-1:0]       wr_en,
   input  logic [PTR_W-1:0]                 wr_base,
   input  logic [FETCH_BANDWIDTH*PKT_W-1:0] wr_data,
   input  logic [PTR_W-1:0]                 rd_base,
   output logic [FETCH_BANDWIDTH*PKT_W-1:0] rd_data
);

   logic [PKT_W-1:0] mem [DEPTH];

   // DEPTH is a power of two, so the PTR_W-bit sum wraps naturally.
   always_ff @(posedge clk) begin
      for (int k = 0; k < FETCH_BANDWIDTH; k++) begin
         if (wr_en[k]) begin
            mem[wr_base + PTR_W'(k)] <= wr_data[k*PKT_W +: PKT_W];
         end
      end
   end

   for (genvar g = 0; g < FETCH_BANDWIDTH; g++) begin : g_rd
      assign rd_data[g*PKT_W +: PKT_W] = mem[rd_base + PTR_W'(g)];
   end

endmodule

// File: rtl/fetch_inst_buffer.sv
// Circular instruction buffer between FetchStage2 and decode, up to four slots in/out per cycle.
// Define FETCH_BUF_BYPASS_EN to forward a bundle straight to decode when the buffer is empty.
module fetch_inst_buffer
   import fetch_buf_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PKT_W = fetch_buf_pkg::PKT_W,
   localparam int unsigned PTR_W = ptr_width(DEPTH),
   localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             flush_i,
   input  logic                             fs2Ready_i,
   input  logic [FETCH_BANDWIDTH-1:0]       instValid_i,
   input  logic [FETCH_BANDWIDTH*PKT_W-1:0] instPacket_i,
   input  logic                             decodeReady_i,
   output logic                             bufferFull_o,
   output logic [FETCH_BANDWIDTH-1:0]       outValid_o,
   output logic [FETCH_BANDWIDTH*PKT_W-1:0] outPacket_o,
   output logic [CNT_W-1:0]                 count_o
);

   logic [PTR_W-1:0]                 head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]                 count_q, count_d;
   logic                             enq, deq, bypass_take;
   logic [2:0]                       n_enq, n_wr, n_deq;
   logic [FETCH_BANDWIDTH-1:0]       wr_en, enq_mask, buf_valid;
   logic [FETCH_BANDWIDTH*PKT_W-1:0] rd_data;

   // Full means fewer than one bundle's worth of free entries.
   assign bufferFull_o = (CNT_W'(DEPTH) - count_q) < CNT_W'(FETCH_BANDWIDTH);
   assign count_o      = count_q;

   always_comb begin
      enq   = fs2Ready_i & ~bufferFull_o & ~flush_i;
      deq   = decodeReady_i & ~flush_i;
      n_enq = enq ? prefix_len(instValid_i) : 3'd0;
      n_deq = 3'd0;
      if (deq) begin
         n_deq = (count_q > CNT_W'(FETCH_BANDWIDTH)) ? 3'd4 : count_q[2:0];
      end
`ifdef FETCH_BUF_BYPASS_EN
      bypass_take = enq & (count_q == '0) & decodeReady_i;
`else
      bypass_take = 1'b0;
`endif
      n_wr = bypass_take ? 3'd0 : n_enq;

      for (int k = 0; k < FETCH_BANDWIDTH; k++) begin
         enq_mask[FETCH_BANDWIDTH-1-k]  = 3'(k) < n_enq;
         wr_en[k]                       = (3'(k) < n_wr) & ~reset;
         buf_valid[FETCH_BANDWIDTH-1-k] = count_q > CNT_W'(k);
      end

      head_d  = head_q + PTR_W'(n_deq);
      tail_d  = tail_q + PTR_W'(n_wr);
      count_d = count_q + CNT_W'(n_wr) - CNT_W'(n_deq);

      outValid_o  = buf_valid;
      outPacket_o = rd_data;
`ifdef FETCH_BUF_BYPASS_EN
      if (enq && (count_q == '0)) begin
         outValid_o  = enq_mask;
         outPacket_o = instPacket_i;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   fetch_buf_ram #(
      .DEPTH (DEPTH),
      .PKT_W (PKT_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_base (tail_q),
      .wr_data (instPacket_i),
      .rd_base (head_q),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Directed self-checking bench for fetch_inst_buffer (DEPTH = 16).
// Expectations follow FETCH_BUF_BYPASS_EN when it is defined for the build.
module tb_fetch_inst_buffer;
   import fetch_buf_pkg::*;

   localparam int unsigned PW = fetch_buf_pkg::PKT_W;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush_i;
   logic          fs2Ready_i;
   logic [3:0]    instValid_i;
   logic [4*PW-1:0] instPacket_i;
   logic          decodeReady_i;
   logic          bufferFull_o;
   logic [3:0]    outValid_o;
   logic [4*PW-1:0] outPacket_o;
   logic [4:0]    count_o;

   int total = 0;
   int passed = 0;
   int fails = 0;

   fetch_inst_buffer #(
      .DEPTH (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .flush_i       (flush_i),
      .fs2Ready_i    (fs2Ready_i),
      .instValid_i   (instValid_i),
      .instPacket_i  (instPacket_i),
      .decodeReady_i (decodeReady_i),
      .bufferFull_o  (bufferFull_o),
      .outValid_o    (outValid_o),
      .outPacket_o   (outPacket_o),
      .count_o       (count_o)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] mk(int id);
      logic [PW-1:0] r;
      r = '0;
      r[31:0] = 32'hC0DE_0000 + 32'(id);
      r[PW-1 -: 8] = 8'(id);
      return r;
   endfunction

   function automatic logic [PW-1:0] slot(int k);
      return outPacket_o[k*PW +: PW];
   endfunction

   task automatic drive(input logic fs, input logic [3:0] v, input int base, input logic dec,
                        input logic fl);
      fs2Ready_i    = fs;
      instValid_i   = v;
      decodeReady_i = dec;
      flush_i       = fl;
      for (int k = 0; k < 4; k++) instPacket_i[k*PW +: PW] = mk(base + k);
   endtask

   // Edge, then give the caller's next inputs time to settle before checking.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 4'b0000, 0, 0, 0);
      repeat (2) tick();
      reset = 1'b0;
      #1;
      chk("reset_count", 128'(count_o), 128'(0));
      chk("reset_valid", 128'(outValid_o), 128'(0));
      chk("reset_full", 128'(bufferFull_o), 128'(0));

      // First full bundle, ids 0..3
      drive(1, 4'b1111, 0, 0, 0);
      #1;
`ifdef FETCH_BUF_BYPASS_EN
      chk("b1_pre_valid", 128'(outValid_o), 128'(4'b1111));
`else
      chk("b1_pre_valid", 128'(outValid_o), 128'(4'b0000));
`endif
      tick();
      drive(1, 4'b1111, 4, 0, 0);
      #1;
      chk("b1_count", 128'(count_o), 128'(4));
      chk("b1_valid", 128'(outValid_o), 128'(4'b1111));
      chk("b1_slot0", 128'(slot(0)), 128'(mk(0)));
      chk("b1_slot3", 128'(slot(3)), 128'(mk(3)));

      tick();
      drive(1, 4'b1111, 8, 0, 0);
      tick();
      drive(1, 4'b1111, 12, 0, 0);
      #1;
      chk("c12_count", 128'(count_o), 128'(12));
      chk("c12_not_full", 128'(bufferFull_o), 128'(0));
      tick();
      // Fifth bundle must be refused; tail has wrapped onto entries 0..3
      drive(1, 4'b1111, 100, 0, 0);
      #1;
      chk("c16_count", 128'(count_o), 128'(16));
      chk("c16_full", 128'(bufferFull_o), 128'(1));
      tick();
      drive(0, 4'b0000, 0, 1, 0);
      #1;
      chk("overflow_count", 128'(count_o), 128'(16));
      chk("overflow_slot0", 128'(slot(0)), 128'(mk(0)));
      chk("overflow_slot3", 128'(slot(3)), 128'(mk(3)));

      // Drain 12 so head sits at 12, entries 12..15
      tick();
      #1;
      chk("deq1_count", 128'(count_o), 128'(12));
      chk("deq1_slot0", 128'(slot(0)), 128'(mk(4)));
      tick();
      tick();
      drive(1, 4'b1100, 20, 0, 0);
      #1;
      chk("deq3_count", 128'(count_o), 128'(4));
      tick();
      // count 6: entries 12..15 then 0..1 across the wrap
      drive(1, 4'b1100, 30, 1, 0);
      #1;
      chk("c6_count", 128'(count_o), 128'(6));
      chk("c6_valid", 128'(outValid_o), 128'(4'b1111));
      chk("c6_slot0", 128'(slot(0)), 128'(mk(12)));
      chk("c6_slot3", 128'(slot(3)), 128'(mk(15)));
      tick();
      drive(1, 4'b1111, 40, 0, 0);
      #1;
      chk("mix_count", 128'(count_o), 128'(4));
      chk("wrap_slot0", 128'(slot(0)), 128'(mk(20)));
      chk("wrap_slot1", 128'(slot(1)), 128'(mk(21)));
      chk("wrap_slot2", 128'(slot(2)), 128'(mk(30)));
      chk("wrap_slot3", 128'(slot(3)), 128'(mk(31)));

      tick();
      drive(1, 4'b1100, 44, 0, 0);
      tick();
      // Flush with enqueue and dequeue also active
      drive(1, 4'b1111, 90, 1, 1);
      #1;
      chk("c10_count", 128'(count_o), 128'(10));
      tick();
      drive(0, 4'b0000, 0, 1, 0);
      #1;
      chk("flush_count", 128'(count_o), 128'(0));
      chk("flush_valid", 128'(outValid_o), 128'(0));
      chk("flush_full", 128'(bufferFull_o), 128'(0));
      tick();
      drive(1, 4'b1000, 50, 0, 0);
      #1;
      chk("empty_deq_count", 128'(count_o), 128'(0));
      tick();
      drive(0, 4'b0000, 0, 1, 0);
      #1;
      chk("post_flush_count", 128'(count_o), 128'(1));
      chk("post_flush_valid", 128'(outValid_o), 128'(4'b1000));
      chk("post_flush_slot0", 128'(slot(0)), 128'(mk(50)));
      tick();

      // Empty buffer, partial bundle, decode ready
      drive(1, 4'b1110, 60, 1, 0);
      #1;
`ifdef FETCH_BUF_BYPASS_EN
      chk("byp_valid", 128'(outValid_o), 128'(4'b1110));
      chk("byp_slot0", 128'(slot(0)), 128'(mk(60)));
      tick();
      drive(0, 4'b0000, 0, 0, 0);
      #1;
      chk("byp_count", 128'(count_o), 128'(0));
      chk("byp_next_valid", 128'(outValid_o), 128'(0));
`else
      chk("nobyp_valid", 128'(outValid_o), 128'(0));
      tick();
      drive(0, 4'b0000, 0, 0, 0);
      #1;
      chk("nobyp_count", 128'(count_o), 128'(3));
      chk("nobyp_next_valid", 128'(outValid_o), 128'(4'b1110));
      chk("nobyp_slot0", 128'(slot(0)), 128'(mk(60)));
`endif

      // Reset in the middle of traffic
      drive(1, 4'b1111, 70, 0, 0);
      tick();
      drive(1, 4'b1111, 80, 1, 0);
      reset = 1'b1;
      #1;
`ifdef FETCH_BUF_BYPASS_EN
      chk("pre_rst_count", 128'(count_o), 128'(4));
`else
      chk("pre_rst_count", 128'(count_o), 128'(7));
`endif
      tick();
      reset = 1'b0;
      drive(0, 4'b0000, 0, 0, 0);
      #1;
      chk("mid_rst_count", 128'(count_o), 128'(0));
      chk("mid_rst_valid", 128'(outValid_o), 128'(0));
      chk("mid_rst_full", 128'(bufferFull_o), 128'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
